// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/done handshake, results held until the next accepted request.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   p_it;
    logic [WIDTH-1:0] q_it;

    always_comb begin
        p_sh  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_sh  = q_q << 1;
        // Subtract via inverted divisor plus carry-in; bit WIDTH+1 is no-borrow.
        trial = {1'b0, p_sh} + {1'b0, ~{1'b0, d_q}} + (WIDTH+2)'(1);
        if (trial[WIDTH+1]) begin
            p_it = trial[WIDTH:0];
            q_it = q_sh | WIDTH'(1);
        end else begin
            p_it = p_sh;
            q_it = q_sh;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    q_d    = Dividend;
                    d_d    = Divisor;
                    p_d    = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (Divisor == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = Dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                p_d   = p_it;
                q_d   = q_it;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = q_it;
                    rem_d   = p_it[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: scoreboard of expected
// results pushed at launch and popped when Done pulses.
module tb_seq_restoring_divider;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         DivByZero;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Dividend(Dividend),
        .Divisor(Divisor),
        .Busy(Busy),
        .Done(Done),
        .Quotient(Quotient),
        .Remainder(Remainder),
        .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b);
        Dividend = a;
        Divisor  = b;
        sb.push_back(model(a, b));
    endtask

    // Counts falling edges until Done is seen, bounded.
    task automatic wait_done(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            n++;
            if (Done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({Busy, Done, Quotient, Remainder, DivByZero} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b/%b/%h/%h/%b, want all 0",
                     Busy, Done, Quotient, Remainder, DivByZero);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({Busy, Done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy/done %b%b want 00", Busy, Done);
        end
    endtask

    task automatic test_basic;
        int n;
        int busy_cnt;
        bit ok;
        exp_t e;
        @(negedge Clk);
        push_op(8'd100, 8'd7);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        busy_cnt = Busy ? 1 : 0;
        wait_done(n, ok);
        n = n + 1;
        e = sb.pop_front();
        n_checks++;
        if (!ok || n != 9) begin
            n_fail++;
            $display("FAIL basic_latency: done after %0d cycles (seen=%0b), want 9", n, ok);
        end
        n_checks++;
        if (Quotient !== e.q || Remainder !== e.r || DivByZero !== e.z) begin
            n_fail++;
            $display("FAIL basic_result: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                     Quotient, Remainder, DivByZero, e.q, e.r, e.z);
        end
        for (int i = 0; i < 20 && Busy; i++) begin
            if (i > 0) busy_cnt++;
            @(negedge Clk);
        end
        busy_cnt = busy_cnt + n - 1;
        n_checks++;
        if (busy_cnt != 9) begin
            n_fail++;
            $display("FAIL basic_busy_len: busy %0d cycles, want 9", busy_cnt);
        end
        n_checks++;
        if (Done !== 1'b0 || Quotient !== 8'd14) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b q=%0d, want done=0 q=14", Done, Quotient);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] av[4] = '{8'd255, 8'd7, 8'd255, 8'd0};
        logic [W-1:0] bv[4] = '{8'd1, 8'd9, 8'd255, 8'd5};
        int n;
        bit ok;
        exp_t e;
        @(negedge Clk);
        push_op(av[0], bv[0]);
        Start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(n, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || Quotient !== e.q || Remainder !== e.r || DivByZero !== e.z) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                         i, Quotient, Remainder, DivByZero, e.q, e.r, e.z);
            end
            if (i > 0) begin
                n_checks++;
                if (n != W + 1) begin
                    n_fail++;
                    $display("FAIL b2b_gap[%0d]: %0d cycles after idle, want %0d", i, n, W + 1);
                end
            end
            if (i < 3) push_op(av[i+1], bv[i+1]);
            else Start = 1'b0;
            @(negedge Clk);
            n_checks++;
            if (Busy !== 1'b0 || Done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle[%0d]: busy=%b done=%b want 0 0", i, Busy, Done);
            end
        end
    endtask

    task automatic test_div_zero;
        int n;
        bit ok;
        exp_t e;
        @(negedge Clk);
        push_op(8'd200, 8'd0);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (Done !== 1'b1 || Quotient !== e.q || Remainder !== e.r || DivByZero !== e.z) begin
            n_fail++;
            $display("FAIL dbz_result: done=%b q=%h r=%0d z=%b want done=1 q=%h r=%0d z=%b",
                     Done, Quotient, Remainder, DivByZero, e.q, e.r, e.z);
        end
        @(negedge Clk);
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_return: busy=%b done=%b want 0 0", Busy, Done);
        end
        push_op(8'd10, 8'd3);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(n, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || Quotient !== e.q || Remainder !== e.r || DivByZero !== e.z) begin
            n_fail++;
            $display("FAIL after_dbz: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                     Quotient, Remainder, DivByZero, e.q, e.r, e.z);
        end
    endtask

    task automatic test_start_ignored;
        int dones;
        exp_t e;
        @(negedge Clk);
        push_op(8'd100, 8'd7);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        dones = 0;
        repeat (2) @(negedge Clk);
        Dividend = 8'd50;
        Divisor  = 8'd5;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (Done) begin
                dones++;
                e = sb.pop_front();
                n_checks++;
                if (Quotient !== e.q || Remainder !== e.r || DivByZero !== e.z) begin
                    n_fail++;
                    $display("FAIL ignore_result: got q=%0d r=%0d want q=%0d r=%0d",
                             Quotient, Remainder, e.q, e.r);
                end
            end
            @(negedge Clk);
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: %0d done pulses, want 1", dones);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        int n;
        bit ok;
        exp_t e;
        @(negedge Clk);
        push_op(8'd100, 8'd7);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        void'(sb.pop_front());
        n_checks++;
        if ({Busy, Done, Quotient, Remainder, DivByZero} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b/%b/%0d/%0d/%b, want all 0",
                     Busy, Done, Quotient, Remainder, DivByZero);
        end
        @(negedge Clk);
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            if (Done || Busy) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: %0d busy/done cycles after reset, want 0", dones);
        end
        push_op(8'd9, 8'd4);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(n, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || Quotient !== e.q || Remainder !== e.r || DivByZero !== e.z) begin
            n_fail++;
            $display("FAIL after_reset: got q=%0d r=%0d want q=%0d r=%0d",
                     Quotient, Remainder, e.q, e.r);
        end
    endtask

    task automatic test_sweep;
        int n;
        bit ok;
        int a;
        int b;
        exp_t e;
        for (int k = 0; k < 2500; k++) begin
            a = $urandom_range(0, 255);
            b = (k % 64 == 0) ? 0 : $urandom_range(0, 255);
            @(negedge Clk);
            push_op(W'(a), W'(b));
            Start = 1'b1;
            @(negedge Clk);
            Start = 1'b0;
            if (!Done) wait_done(n, ok);
            else ok = 1'b1;
            e = sb.pop_front();
            n_checks++;
            if (!ok || Quotient !== e.q || Remainder !== e.r || DivByZero !== e.z ||
                (b != 0 && (a != int'(Quotient) * b + int'(Remainder) ||
                            int'(Remainder) >= b))) begin
                n_fail++;
                $display("FAIL sweep %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                         a, b, Quotient, Remainder, DivByZero, e.q, e.r, e.z);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
